// File: rtl/ro_entropy_packer.sv
// Ring-oscillator entropy packer: XOR-tree fold, decimation, repetition-count
// health test, optional von Neumann debias, and word packing with valid/ready.
module ro_entropy_packer #(
    parameter int NUM_RO     = 8,
    parameter int WORD_WIDTH = 32,
    parameter int SAMPLE_DIV = 4,
    parameter int REP_LIMIT  = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  mode,
    input  logic [NUM_RO-1:0]     ro_bits,
    output logic [WORD_WIDTH-1:0] word_out,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic                  health_fail
);

    localparam int TREE_N = 2 * NUM_RO - 1;
    localparam int CNT_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int RUN_W  = $clog2(REP_LIMIT + 1);
    localparam int NB_W   = $clog2(WORD_WIDTH + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(REP_LIMIT);
    localparam logic [NB_W-1:0]  NB_FULL  = NB_W'(WORD_WIDTH);

    logic [TREE_N-1:0]     tree_q, tree_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [RUN_W-1:0]      run_q, run_d;
    logic                  last_q, last_d;
    logic                  fail_q, fail_d;
    logic                  phase_q, phase_d;
    logic                  pair_a_q, pair_a_d;
    logic                  mode_q, mode_d;
    logic [WORD_WIDTH-1:0] acc_q, acc_d;
    logic [WORD_WIDTH-1:0] word_q, word_d;
    logic [NB_W-1:0]       nbits_q, nbits_d;
    logic                  valid_q, valid_d;

    logic sample;
    logic strobe;
    logic healthy;
    logic phase_eff;
    logic bit_vld;
    logic bit_val;
    logic xfer;

    // Heap-ordered tree: leaves capture ro_bits, each inner node is one
    // registered XOR of its children, so the root lags the leaves by log2 levels.
    always_comb begin
        tree_d = tree_q;
        tree_d[TREE_N-1 -: NUM_RO] = ro_bits;
        for (int i = 0; i < NUM_RO - 1; i++) begin
            tree_d[i] = tree_q[2*i+1] ^ tree_q[2*i+2];
        end
    end

    assign sample      = tree_q[0];
    assign word_valid  = valid_q && !fail_q;
    assign word_out    = word_q;
    assign health_fail = fail_q;
    assign xfer        = word_valid && word_ready;

    always_comb begin
        strobe  = enable && (cnt_q == CNT_LAST);
        cnt_d   = (!enable || strobe) ? '0 : cnt_q + CNT_W'(1);
        run_d   = run_q;
        last_d  = last_q;
        fail_d  = fail_q;
        healthy = 1'b0;
        if (strobe && !fail_q) begin
            if (run_q == '0 || sample != last_q) begin
                run_d = RUN_W'(1);
            end else begin
                run_d = run_q + RUN_W'(1);
            end
            last_d = sample;
            if (run_d == RUN_MAX) begin
                fail_d = 1'b1;
            end else begin
                healthy = 1'b1;
            end
        end
    end

    // A mode change this cycle discards any half-collected pair.
    always_comb begin
        mode_d    = mode;
        phase_eff = phase_q && (mode == mode_q);
        phase_d   = enable ? phase_eff : 1'b0;
        pair_a_d  = pair_a_q;
        bit_vld   = 1'b0;
        bit_val   = sample;
        if (healthy) begin
            if (!mode) begin
                bit_vld = 1'b1;
            end else if (!phase_eff) begin
                phase_d  = 1'b1;
                pair_a_d = sample;
            end else begin
                phase_d = 1'b0;
                bit_vld = (sample != pair_a_q);
                bit_val = pair_a_q;
            end
        end
    end

    always_comb begin
        acc_d   = acc_q;
        nbits_d = nbits_q;
        word_d  = word_q;
        valid_d = valid_q && !xfer;
        if (fail_q) begin
            acc_d   = '0;
            nbits_d = '0;
            valid_d = 1'b0;
        end else begin
            if (bit_vld && nbits_q != NB_FULL) begin
                acc_d   = {acc_q[WORD_WIDTH-2:0], bit_val};
                nbits_d = nbits_q + NB_W'(1);
            end
            if (nbits_d == NB_FULL && (!valid_q || xfer)) begin
                word_d  = acc_d;
                valid_d = 1'b1;
                nbits_d = '0;
                acc_d   = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tree_q   <= '0;
            cnt_q    <= '0;
            run_q    <= '0;
            last_q   <= 1'b0;
            fail_q   <= 1'b0;
            phase_q  <= 1'b0;
            pair_a_q <= 1'b0;
            mode_q   <= 1'b0;
            acc_q    <= '0;
            word_q   <= '0;
            nbits_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            tree_q   <= tree_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
            last_q   <= last_d;
            fail_q   <= fail_d;
            phase_q  <= phase_d;
            pair_a_q <= pair_a_d;
            mode_q   <= mode_d;
            acc_q    <= acc_d;
            word_q   <= word_d;
            nbits_q  <= nbits_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: doc/ro_entropy_packer.md
# ro_entropy_packer

Parametrised successor to the ring-oscillator combiner. It folds NUM_RO raw oscillator samples through a registered XOR tree and decimates the combined bit with a sample divider. Each sample passes through a continuous repetition-count health test and optional von Neumann debiasing. Surviving bits are packed into WORD_WIDTH-bit words and delivered on a valid/ready interface. The RO array is instantiated by the parent; this block receives its raw outputs.

## Interface
- NUM_RO, 8: oscillator count; power of two, ≥2.
- WORD_WIDTH, 32: output word width; ≥2.
- SAMPLE_DIV, 4: tree output sampled once every SAMPLE_DIV enabled cycles; ≥1.
- REP_LIMIT, 32: run length of identical samples that declares failure; ≥2.

- clock  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- enable  in  1  run sampling; low freezes sampling only.
- mode  in  1  0 = raw bits, 1 = von Neumann debias.
- ro_bits  in  NUM_RO  asynchronous RO outputs.
- word_out  out  WORD_WIDTH  packed random word.
- word_valid  out  1  word_out holds an untransferred word.
- word_ready  in  1  consumer accepts word this cycle.
- health_fail  out  1  sticky repetition-count failure.

## Operation
- Capture: ro_bits registered every cycle, regardless of enable.
- XOR tree: L = log2(NUM_RO) registered pairwise-XOR layers run every cycle. comb = XOR of the ro_bits captured L+1 cycles earlier.
- Divider: cnt counts 0..SAMPLE_DIV-1 while enable=1.
  - strobe when enable && cnt==SAMPLE_DIV-1; cnt then wraps to 0.
  - enable=0: cnt forced to 0.
- Health test, on each strobe with sample s:
  - run=1 if first sample since reset or s!=last; otherwise run=run+1; last=s.
  - When run reaches REP_LIMIT, health_fail←1. The triggering sample is not packed.
  - health_fail=1: strobes ignored, accumulator cleared, word_valid forced 0. Only reset clears it.
- Debias:
  - mode 0: every healthy sample is a packed bit.
  - mode 1: samples taken in pairs (a,b). a!=b → pack a. a==b → discard both.
  - Pair phase cleared on reset, enable=0, or any change of mode.
- Packer:
  - acc shifts left, new bit into LSB; nbits counts 0..WORD_WIDTH.
  - When nbits reaches WORD_WIDTH and the output register is free (or is being transferred this cycle), acc moves to word_out, word_valid←1, nbits←0.
  - If the output register is occupied and not transferring, acc stays full and further bits are dropped. Health test still runs on those samples.
- Handshake:
  - Transfer occurs when word_valid && word_ready.
  - word_out stays stable while word_valid=1.
  - A transfer and a full-acc load in the same cycle leave word_valid=1 with the new word.
- enable=0: acc, nbits, word_out and the handshake are retained and keep working.

## Timing
- Reset values:
  - word_out=0, word_valid=0, health_fail=0.
  - acc, nbits, cnt, run, pair phase all 0.
  - XOR pipeline registers 0.
- Latency:
  - ro_bits→comb: L+1 cycles.
  - First strobe: the SAMPLE_DIV-th cycle with enable=1 after reset or after enable rises.
- word_valid rises the cycle after the strobe that supplies the WORD_WIDTH-th bit, when the output register is free.
- health_fail rises the cycle after the strobe that makes run==REP_LIMIT.
- Reset mid-word or mid-handshake:
  - The partial or pending word is lost.
  - word_valid=0 the cycle after reset is sampled high.
- mode and enable are sampled on the same edge as the strobe.

## Test plan
- Defaults, mode 0: ro_bits held at 0x0F, so comb=0. After 32 strobes, health_fail=1 and no word_valid (31 bits packed, 32nd rejected). After that, acc is cleared.
- SAMPLE_DIV=1, mode 0, REP_LIMIT=32, word_ready=1: drive ro_bits so the sampled comb alternates 1,0,1,0…. Expect word_out=0xAAAAAAAA and a single-cycle word_valid pulse.
- Mode 1, pairs (0,1),(1,1),(1,0),(0,0): expect packed bits 0,1 only. nbits=2 after the 8 samples.
- Backpressure: word_ready=0 for 3 words of alternating samples. Expect:
  - first word held stable on word_out.
  - second word held in acc, further bits dropped.
  - raising word_ready for one cycle transfers word 1; the next cycle shows word 2 with word_valid=1.
- enable toggles low for 5 cycles mid-word. Expect:
  - no strobes while low; nbits unchanged.
  - pending word still transfers.
  - first strobe comes SAMPLE_DIV cycles after enable rises.
- Assert reset while word_valid=1 and health_fail=1. The next cycle all outputs are 0, and a fresh 32-strobe sequence produces a valid word again.
